// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared types and constants for the multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // RISC-V results for x/0 quotient and the most negative signed value
    localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = {DIV_WIDTH{1'b1}};
    localparam logic [DIV_WIDTH-1:0] INT_MIN       = {1'b1, {(DIV_WIDTH-1){1'b0}}};

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One radix-2 restoring division iteration (shift, trial
//               subtract, restore). Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH:0]   r_o,
    output logic [WIDTH-1:0] q_o
);

    // Shifted partial remainder carries one extra top bit so the borrow of
    // the trial subtraction lands in a bit that can never be a magnitude bit.
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_ge;

    assign w_shift = {r_i, q_i[WIDTH-1]};
    assign w_diff  = w_shift - {2'b00, d_i};
    assign w_ge    = ~w_diff[WIDTH+1];

    assign r_o = w_ge ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
    assign q_o = {q_i[WIDTH-2:0], w_ge};

endmodule : div_step
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Iterative 32-cycle restoring divider, signed/unsigned, with
//               RISC-V divide-by-zero and overflow semantics and a
//               start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import mdu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH:0]   r_q,     r_d;
    logic [WIDTH-1:0] q_q,     q_d;
    logic [WIDTH-1:0] dvs_q,   dvs_d;
    logic             qneg_q,  qneg_d;
    logic             rneg_q,  rneg_d;
    logic [WIDTH-1:0] quo_q,   quo_d;
    logic [WIDTH-1:0] rem_q,   rem_d;

    logic [WIDTH:0]   w_step_r;
    logic [WIDTH-1:0] w_step_q;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    assign w_mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
    assign w_mag_b = (is_signed && b[WIDTH-1]) ? -b : b;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (dvs_q),
        .r_o (w_step_r),
        .q_o (w_step_q)
    );

    // State and datapath registers; reset discards any partial result
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state, iteration and sign fix-up logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        quo_d   = quo_q;
        rem_d   = rem_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvs_d  = w_mag_b;
                    qneg_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    rneg_d = is_signed & a[WIDTH-1];
                    cnt_d  = '0;
                    // Corner cases preload the final Q/R and pass through FIX
                    // with no sign correction, giving one busy cycle before done.
                    if (b == '0) begin
                        q_d     = DIV_BY_ZERO_Q;
                        r_d     = {1'b0, a};
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = FIX;
                    end else if (is_signed && (a == INT_MIN) && (b == '1)) begin
                        q_d     = INT_MIN;
                        r_d     = '0;
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = FIX;
                    end else begin
                        q_d     = w_mag_a;
                        r_d     = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                r_d   = w_step_r;
                q_d   = w_step_q;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quo_d   = qneg_q ? -q_q : q_q;
                rem_d   = rneg_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q == CALC) || (state_q == FIX);
    assign done      = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule : seq_divider
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Directed self-checking bench for seq_divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_checks = 0;
    int n_errors = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Issue one operation, optionally inject a second start at cycle inj,
    // and check latency, busy length, results and that results are held.
    task automatic run_op(input string tag, input logic sg,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] eq, input logic [31:0] er,
                          input int lat, input int inj);
        int n;
        int nbusy;
        @(negedge clk);
        start     = 1'b1;
        is_signed = sg;
        a         = av;
        b         = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 32'hA5A5_A5A5;
        b     = 32'h5A5A_5A5A;
        n     = 0;
        nbusy = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == inj) begin
                start = 1'b1;
                a     = 32'd9;
                b     = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (busy) nbusy++;
        end while (!done && n < 200);
        check({tag, " latency"}, n, lat);
        check({tag, " busy_cycles"}, nbusy, lat - 1);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        @(negedge clk);
        check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, " q_hold"}, quotient, eq);
    endtask

    initial begin
        int n;
        rstn      = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        run_op("u100/7",     1'b0, 32'd100,        32'd7,        32'd14,        32'd2,        34, 0);
        run_op("s-7/2",      1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, 0);
        run_op("u-7/2",      1'b0, 32'hFFFF_FFF9,  32'd2,        32'h7FFF_FFFC, 32'd1,        34, 0);
        run_op("u5/0",       1'b0, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5,        2,  0);
        run_op("s5/0",       1'b1, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5,        2,  0);
        run_op("s-5/0",      1'b1, 32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFB, 2, 0);
        run_op("s_ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,       2,  0);
        run_op("u_min/-1",   1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 34, 0);
        run_op("ignore9/3",  1'b0, 32'd100,        32'd7,        32'd14,        32'd2,        34, 10);
        run_op("u9/3",       1'b0, 32'd9,          32'd3,        32'd3,         32'd0,        34, 0);
        run_op("u_b1",       1'b0, 32'd12345,      32'd1,        32'd12345,     32'd0,        34, 0);
        run_op("u_a0",       1'b0, 32'd0,          32'd7,        32'd0,         32'd0,        34, 0);
        run_op("u_altb",     1'b0, 32'd5,          32'd9,        32'd0,         32'd5,        34, 0);
        run_op("u_aeqb",     1'b0, 32'hDEAD_BEEF,  32'hDEAD_BEEF, 32'd1,        32'd0,        34, 0);
        run_op("u_big",      1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'd1,        32'd1,        34, 0);
        run_op("s-100/7",    1'b1, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF2, 32'hFFFF_FFFE, 34, 0);
        run_op("s100/-7",    1'b1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,       34, 0);
        run_op("s-100/-7",   1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,       32'hFFFF_FFFE, 34, 0);
        run_op("s_min/1",    1'b1, 32'h8000_0000,  32'd1,        32'h8000_0000, 32'd0,        34, 0);
        run_op("s_min/2",    1'b1, 32'h8000_0000,  32'd2,        32'hC000_0000, 32'd0,        34, 0);

        // Reset in the 15th CALC cycle of 100/7 clears everything at once
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b0;
        a         = 32'd100;
        b         = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (n < 15) begin
            @(negedge clk);
            n++;
        end
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        rstn = 1'b0;
        #1;
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset done", {31'd0, done}, 32'd0);
        check("midreset quotient", quotient, 32'd0);
        check("midreset remainder", remainder, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run_op("u_ffff/16",  1'b0, 32'hFFFF_FFFF,  32'h10,       32'h0FFF_FFFF, 32'hF,        34, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_seq_divider
`default_nettype wire
